// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, receiver state encoding and parity helper.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;
  localparam uart_state_t ST_BREAK  = 3'd5;

  // Even parity bit: the value that makes the total count of ones even.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for the asynchronous serial line; flops reset to the idle level.
module uart_sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Double-register the line into the clk domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_rx_serial.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit, with a
// valid/ready output register and parity, framing and overrun pulses.
module uart_rx_serial
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_i,
  output logic [UART_DATA_BITS-1:0] data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      parity_err_o,
  output logic                      frame_err_o,
  output logic                      overrun_o,
  output logic                      busy_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_BITS - 1);

  logic                      rx_s;
  uart_state_t               state_r, state_s;
  logic [CNT_W-1:0]          cyc_r, cyc_s;
  logic [BIT_W-1:0]          bit_r, bit_s;
  logic [UART_DATA_BITS-1:0] shift_r, shift_s;
  logic                      perr_r, perr_s;
  logic                      stop_done_s, stop_high_s;
  logic                      good_s;
  logic [UART_DATA_BITS-1:0] data_r, data_s;
  logic                      valid_r, valid_s;
  logic                      overrun_s;
  logic                      parity_err_r, frame_err_r, overrun_r, busy_r;

  uart_sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_i),
    .q     (rx_s)
  );

  // Frame FSM: counters advance each clk; samples are taken at mid-bit.
  always_comb begin
    state_s     = state_r;
    cyc_s       = cyc_r;
    bit_s       = bit_r;
    shift_s     = shift_r;
    perr_s      = perr_r;
    stop_done_s = 1'b0;
    stop_high_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!rx_s) begin
          state_s = ST_START;
          cyc_s   = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (cyc_r == HALF_M1) begin
          cyc_s   = '0;
          bit_s   = '0;
          state_s = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cyc_s = cyc_r + CNT_W'(1'b1);
        end
      end
      ST_DATA: begin
        if (cyc_r == FULL_M1) begin
          cyc_s          = '0;
          shift_s[bit_r] = rx_s;
          if (bit_r == LAST_BIT) begin
            bit_s   = '0;
            state_s = ST_PARITY;
          end else begin
            bit_s = bit_r + BIT_W'(1'b1);
          end
        end else begin
          cyc_s = cyc_r + CNT_W'(1'b1);
        end
      end
      ST_PARITY: begin
        if (cyc_r == FULL_M1) begin
          cyc_s   = '0;
          perr_s  = (rx_s != even_parity(shift_r));
          state_s = ST_STOP;
        end else begin
          cyc_s = cyc_r + CNT_W'(1'b1);
        end
      end
      ST_STOP: begin
        if (cyc_r == FULL_M1) begin
          cyc_s       = '0;
          stop_done_s = 1'b1;
          stop_high_s = rx_s;
          state_s     = rx_s ? ST_IDLE : ST_BREAK;
        end else begin
          cyc_s = cyc_r + CNT_W'(1'b1);
        end
      end
      ST_BREAK: begin
        if (rx_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BREAK;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cyc_s   = '0;
        bit_s   = '0;
      end
    endcase
  end

  assign good_s = stop_done_s && stop_high_s && !perr_r;

  // Output holding register: a new byte wins over a same-cycle handshake.
  always_comb begin
    data_s    = data_r;
    valid_s   = valid_r;
    overrun_s = 1'b0;
    if (good_s) begin
      if (valid_r && !ready_i) begin
        overrun_s = 1'b1;
      end else begin
        data_s  = shift_r;
        valid_s = 1'b1;
      end
    end else if (valid_r && ready_i) begin
      valid_s = 1'b0;
    end else begin
      valid_s = valid_r;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cyc_r        <= '0;
      bit_r        <= '0;
      shift_r      <= '0;
      perr_r       <= 1'b0;
      data_r       <= '0;
      valid_r      <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      cyc_r        <= cyc_s;
      bit_r        <= bit_s;
      shift_r      <= shift_s;
      perr_r       <= perr_s;
      data_r       <= data_s;
      valid_r      <= valid_s;
      parity_err_r <= stop_done_s && stop_high_s && perr_r;
      frame_err_r  <= stop_done_s && !stop_high_s;
      overrun_r    <= overrun_s;
      busy_r       <= (state_s != ST_IDLE);
    end
  end

  assign data_o       = data_r;
  assign valid_o      = valid_r;
  assign parity_err_o = parity_err_r;
  assign frame_err_o  = frame_err_r;
  assign overrun_o    = overrun_r;
  assign busy_o       = busy_r;

endmodule

// File: tb/tb_uart_rx_serial.sv
// Self-checking bench for uart_rx_serial: directed scenarios plus random frames
// checked against an expected-outcome model derived from the frame rules.
module tb_uart_rx_serial;

  localparam int CPB     = 16;
  localparam int LATENCY = 171;  // drive of start bit to valid_o visible: 2 sync + 1 + 10.5*CPB

  logic       clk;
  logic       reset;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  int         cyc       = 0;
  int         valid_hi  = 0;
  int         perr_cnt  = 0;
  int         ferr_cnt  = 0;
  int         ovr_cnt   = 0;
  logic       prev_v    = 1'b0;
  int         rise_q[$];
  logic [7:0] acc_q[$];

  uart_rx_serial #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_i         (rx_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .parity_err_o (parity_err_o),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Observation of outputs on the falling edge.
  always @(negedge clk) begin
    if (valid_o) valid_hi = valid_hi + 1;
    if (valid_o && !prev_v) rise_q.push_back(cyc);
    prev_v = valid_o;
    if (valid_o && ready_i) acc_q.push_back(data_o);
    if (parity_err_o) perr_cnt = perr_cnt + 1;
    if (frame_err_o) ferr_cnt = ferr_cnt + 1;
    if (overrun_o) ovr_cnt = ovr_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx_i = f[i];
      tick(CPB);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_i = 1'b1; ready_i = 1'b0;
    tick(3);
    n_checks++; if (data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", data_o); end
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    n_checks++;
    if ({parity_err_o, frame_err_o, overrun_o} !== 3'b000) begin
      n_fail++; $display("FAIL reset_pulses got=%b exp=000", {parity_err_o, frame_err_o, overrun_o});
    end
    reset = 1'b0;
    tick(4);
  endtask

  task automatic test_basic();
    int c0, rb, ab, vb, pb, fb, ob;
    logic [7:0] d;
    d = 8'hA5;
    ready_i = 1'b1;
    rb = rise_q.size(); ab = acc_q.size(); vb = valid_hi; pb = perr_cnt; fb = ferr_cnt; ob = ovr_cnt;
    c0 = cyc;
    send_frame(d, ^d, 1'b1);
    tick(10);
    n_checks++;
    if (acc_q.size() != ab + 1 || acc_q[acc_q.size()-1] !== d) begin
      n_fail++; $display("FAIL basic_data count=%0d last=%h exp=1 byte %h", acc_q.size() - ab, acc_q.size() > 0 ? acc_q[acc_q.size()-1] : 8'h00, d);
    end
    n_checks++;
    if (rise_q.size() != rb + 1 || rise_q[rise_q.size()-1] - c0 != LATENCY) begin
      n_fail++; $display("FAIL basic_latency rises=%0d lat=%0d exp=1 rise at %0d", rise_q.size() - rb, rise_q.size() > 0 ? rise_q[rise_q.size()-1] - c0 : -1, LATENCY);
    end
    n_checks++; if (valid_hi - vb != 1) begin n_fail++; $display("FAIL basic_valid_cycles got=%0d exp=1", valid_hi - vb); end
    n_checks++;
    if (perr_cnt != pb || ferr_cnt != fb || ovr_cnt != ob) begin
      n_fail++; $display("FAIL basic_errors perr=%0d ferr=%0d ovr=%0d exp=0 0 0", perr_cnt - pb, ferr_cnt - fb, ovr_cnt - ob);
    end
  endtask

  task automatic test_parity();
    int vb, pb, fb;
    vb = valid_hi; pb = perr_cnt; fb = ferr_cnt;
    send_frame(8'h01, 1'b0, 1'b1);
    tick(10);
    n_checks++; if (perr_cnt - pb != 1) begin n_fail++; $display("FAIL parity_pulse got=%0d exp=1", perr_cnt - pb); end
    n_checks++; if (valid_hi != vb) begin n_fail++; $display("FAIL parity_valid got=%0d exp=0", valid_hi - vb); end
    n_checks++; if (ferr_cnt != fb) begin n_fail++; $display("FAIL parity_ferr got=%0d exp=0", ferr_cnt - fb); end
  endtask

  task automatic test_frame();
    int vb, pb, fb;
    logic [7:0] d;
    d = 8'h3C;
    vb = valid_hi; pb = perr_cnt; fb = ferr_cnt;
    send_frame(d, ^d, 1'b0);
    tick(40);
    n_checks++; if (ferr_cnt - fb != 1) begin n_fail++; $display("FAIL frame_pulse got=%0d exp=1", ferr_cnt - fb); end
    n_checks++; if (perr_cnt != pb || valid_hi != vb) begin n_fail++; $display("FAIL frame_side perr=%0d valid=%0d exp=0 0", perr_cnt - pb, valid_hi - vb); end
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL frame_busy_low_line got=%b exp=1", busy_o); end
    rx_i = 1'b1;
    tick(2);
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL frame_busy_sync got=%b exp=1", busy_o); end
    tick(1);
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL frame_busy_release got=%b exp=0", busy_o); end
    tick(5);
  endtask

  task automatic test_glitch();
    int vb, pb, fb;
    vb = valid_hi; pb = perr_cnt; fb = ferr_cnt;
    rx_i = 1'b0;
    tick(5);
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_start got=%b exp=1", busy_o); end
    rx_i = 1'b1;
    tick(20);
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_end got=%b exp=0", busy_o); end
    n_checks++;
    if (valid_hi != vb || perr_cnt != pb || ferr_cnt != fb) begin
      n_fail++; $display("FAIL glitch_outputs valid=%0d perr=%0d ferr=%0d exp=0 0 0", valid_hi - vb, perr_cnt - pb, ferr_cnt - fb);
    end
  endtask

  task automatic test_back_to_back();
    int ob, ab;
    ready_i = 1'b0;
    ob = ovr_cnt; ab = acc_q.size();
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    tick(5);
    n_checks++; if (data_o !== 8'h11 || valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_hold data=%h valid=%b exp=11 1", data_o, valid_o); end
    n_checks++; if (ovr_cnt - ob != 1) begin n_fail++; $display("FAIL b2b_overrun got=%0d exp=1", ovr_cnt - ob); end
    ready_i = 1'b1;
    tick(1);
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_clear got=%b exp=0", valid_o); end
    n_checks++;
    if (acc_q.size() != ab + 1 || acc_q[acc_q.size()-1] !== 8'h11) begin
      n_fail++; $display("FAIL b2b_accepted count=%0d exp=1 byte 11", acc_q.size() - ab);
    end
    tick(4);
  endtask

  task automatic test_same_cycle();
    int ob, ab;
    logic [7:0] b;
    b = 8'h44;
    ready_i = 1'b0;
    send_frame(8'h33, 1'b0, 1'b1);
    tick(4);
    ob = ovr_cnt; ab = acc_q.size();
    fork
      send_frame(b, ^b, 1'b1);
      begin
        tick(LATENCY - 1);
        ready_i = 1'b1;
        tick(1);
        n_checks++; if (valid_o !== 1'b1 || data_o !== b) begin n_fail++; $display("FAIL same_cycle_load data=%h valid=%b exp=44 1", data_o, valid_o); end
        tick(1);
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL same_cycle_clear got=%b exp=0", valid_o); end
      end
    join
    n_checks++; if (ovr_cnt != ob) begin n_fail++; $display("FAIL same_cycle_overrun got=%0d exp=0", ovr_cnt - ob); end
    n_checks++;
    if (acc_q.size() != ab + 2 || acc_q[ab] !== 8'h33 || acc_q[ab+1] !== b) begin
      n_fail++; $display("FAIL same_cycle_accepted count=%0d exp=2 (33,44)", acc_q.size() - ab);
    end
    tick(4);
  endtask

  task automatic test_reset_mid();
    int pb, fb, ob, ab;
    ready_i = 1'b0;
    send_frame(8'h77, 1'b0, 1'b1);
    tick(2);
    n_checks++; if (valid_o !== 1'b1 || data_o !== 8'h77) begin n_fail++; $display("FAIL rmid_preload data=%h valid=%b exp=77 1", data_o, valid_o); end
    pb = perr_cnt; fb = ferr_cnt; ob = ovr_cnt;
    rx_i = 1'b0;
    tick(CPB);
    rx_i = 1'b1;
    tick(4 * CPB + CPB / 2);
    reset = 1'b1;
    tick(3);
    n_checks++;
    if (data_o !== 8'h00 || valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL rmid_reset data=%h valid=%b busy=%b exp=00 0 0", data_o, valid_o, busy_o);
    end
    reset = 1'b0;
    tick(6 * CPB);
    n_checks++;
    if (perr_cnt != pb || ferr_cnt != fb || ovr_cnt != ob) begin
      n_fail++; $display("FAIL rmid_pulses perr=%0d ferr=%0d ovr=%0d exp=0 0 0", perr_cnt - pb, ferr_cnt - fb, ovr_cnt - ob);
    end
    ready_i = 1'b1;
    ab = acc_q.size();
    send_frame(8'h5A, 1'b0, 1'b1);
    tick(5);
    n_checks++;
    if (acc_q.size() != ab + 1 || acc_q[acc_q.size()-1] !== 8'h5A) begin
      n_fail++; $display("FAIL rmid_next_frame count=%0d exp=1 byte 5a", acc_q.size() - ab);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int exp_perr, exp_ferr, pb, fb, ab, kind;
    logic [7:0] d;
    logic p;
    ready_i = 1'b1;
    exp_perr = 0; exp_ferr = 0;
    pb = perr_cnt; fb = ferr_cnt; ab = acc_q.size();
    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom);
      kind = int'($urandom_range(0, 7));
      p = ^d;
      if (kind == 0) begin
        send_frame(d, ~p, 1'b1);
        exp_perr++;
        tick(int'($urandom_range(0, 12)));
      end else if (kind == 1) begin
        send_frame(d, p, 1'b0);
        exp_ferr++;
        tick(int'($urandom_range(0, 20)));
        rx_i = 1'b1;
        tick(int'($urandom_range(4, 12)));
      end else begin
        send_frame(d, p, 1'b1);
        exp_q.push_back(d);
        tick(int'($urandom_range(0, 12)));
      end
    end
    tick(10);
    n_checks++; if (perr_cnt - pb != exp_perr) begin n_fail++; $display("FAIL rand_parity got=%0d exp=%0d", perr_cnt - pb, exp_perr); end
    n_checks++; if (ferr_cnt - fb != exp_ferr) begin n_fail++; $display("FAIL rand_frame got=%0d exp=%0d", ferr_cnt - fb, exp_ferr); end
    n_checks++;
    if (acc_q.size() - ab != exp_q.size()) begin
      n_fail++; $display("FAIL rand_count got=%0d exp=%0d", acc_q.size() - ab, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (acc_q[ab+i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_byte%0d got=%h exp=%h", i, acc_q[ab+i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; rx_i = 1'b1; ready_i = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_frame();
    test_glitch();
    test_back_to_back();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
